gci_std_display_vram_write_arbiter: RTL and testbench
=====================================================

// Module: gci_std_display_vram_write_arbiter
// PURPOSE
//  Shares the single VRAM write port (REQ/ADDR/DATA, WAIT = write FIFO full) between P_N write requesters.
//  Requesters are the bus command controller and on-chip drawing engines (fill/blit).
//  Round-robin arbitration with optional locked bursts; a one-entry output stage drives the VRAM controller.
//  Sits between the requesters and the VRAM controller write interface, all in the iCLOCK domain.
// PARAMETERS
//  P_N          2    number of requesters (2..4); index 0 is first after reset
//  P_ADDR_W     19   VRAM word address width
//  P_DATA_W     16   VRAM data width
//  P_MAX_BURST  16   max beats per grant (1..256); forces release even if lock held
// PORTS
//  iCLOCK            in   1             system clock; single clock domain
//  iRESET            in   1             asynchronous, active-high reset
//  iREQ              in   P_N           per-requester write valid
//  iREQ_LOCK         in   P_N           keep grant after this beat (burst)
//  iREQ_ADDR         in   P_N*P_ADDR_W  packed addresses, requester i at [i*P_ADDR_W +: P_ADDR_W]
//  iREQ_DATA         in   P_N*P_DATA_W  packed data, same packing
//  oREQ_BUSY         out  P_N           1 = beat not accepted this cycle
//  oGRANT            out  P_N           one-hot current owner (0 when arbitrating)
//  iVRAM_WAIT        in   1             VRAM write FIFO full
//  oVRAM_WRITE_REQ   out  1             output stage valid
//  oVRAM_WRITE_ADDR  out  P_ADDR_W      output address
//  oVRAM_WRITE_DATA  out  P_DATA_W      output data
// BEHAVIOUR
//  Reset values
//   - state=ARB, oGRANT=0, oREQ_BUSY=all 1, oVRAM_WRITE_REQ=0, ADDR/DATA=0, beat count=0.
//   - RR pointer=P_N-1, so requester 0 has top priority.
//  Handshakes
//   - Requester beat accepted when iREQ[i] & !oREQ_BUSY[i].
//   - VRAM beat consumed when oVRAM_WRITE_REQ & !iVRAM_WAIT.
//   - Output stage holds REQ/ADDR/DATA stable while iVRAM_WAIT=1.
//  slot_free = !oVRAM_WRITE_REQ | !iVRAM_WAIT (combinational)
//   - Owner g: oREQ_BUSY[g] = !slot_free.
//   - All non-owners: BUSY=1.
//  FSM
//   - ARB: if |iREQ, grant the first requesting index after RR pointer (wrapping).
//     Register oGRANT and the pointer; next state OWN, count=0. If no request, stay in ARB.
//   - OWN: each accepted beat loads the output stage and increments count.
//     Go to ARB (oGRANT=0) on accepted beat with iREQ_LOCK[g]=0,
//     or on accepted beat with count+1==P_MAX_BURST,
//     or in any cycle with iREQ[g]=0 & iREQ_LOCK[g]=0.
//     Owner with iREQ=0 & LOCK=1 keeps the grant (gap allowed).
//  Latency
//   - Request in ARB: granted at next edge; first beat accepted in first OWN cycle if slot_free.
//   - Accepted beat visible on oVRAM_WRITE_* at the next edge.
//   - Handover costs exactly one ARB cycle with no acceptance.
//  Output stage
//   - Accept: load ADDR/DATA, REQ=1.
//   - Consumed with no new accept: REQ=0; ADDR/DATA hold their last value.
//   - Consume and accept in the same cycle: back-to-back, no bubble.
//  Boundaries
//   - P_MAX_BURST=1: every beat releases.
//   - Count never wraps; width is clog2(P_MAX_BURST+1).
//   - iVRAM_WAIT held high indefinitely: stage and grant hold, no loss, no duplicate.
//   - Reset mid-burst: pending output beat dropped; all state to reset values asynchronously.
//   - Simultaneous all-request: strict rotation 0,1,..,P_N-1 across grants.
// STRUCTURE
//  - Shared header gci_std_display_parameter.h: VRAM address/data widths, FSM state encodings (ARB=1'b0, OWN=1'b1).
//  - Sub-module gci_std_display_rr_select: combinational, P_N requests + pointer -> one-hot winner + valid.
//  - Top holds FSM, beat counter, output stage, mux.
// TESTING
//  - Reset: after iRESET pulse, oVRAM_WRITE_REQ=0, oGRANT=0, oREQ_BUSY=all 1; iREQ=01 -> oGRANT=01 next cycle.
//  - Single beats: both requesters hold iREQ, LOCK=0, WAIT=0.
//    Accepted beats alternate 0,1,0,1 with one ARB cycle between each; ADDR/DATA match the sources.
//  - Burst: req0 LOCK=1 with 20 beats, P_MAX_BURST=16, req1 waiting.
//    Exactly 16 req0 beats back-to-back, then req1 granted, then req0 resumes.
//  - Backpressure: WAIT=1 for 10 cycles mid-burst.
//    Output stable, oREQ_BUSY[g]=1; after WAIT=0 beats continue with no loss or duplicate (scoreboard).
//  - Gap with lock: owner drops iREQ with LOCK=1 for 3 cycles -> grant kept. LOCK=0 & iREQ=0 -> ARB next cycle.
//  - Reset mid-burst with pending beat under WAIT=1: outputs clear immediately; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/gci_std_display_vram_write_arbiter_pkg.sv
// Shared VRAM geometry and arbiter FSM encoding for the display VRAM write path.
// Imported by the write arbiter, its interface and its round-robin selector.
package gci_std_display_vram_write_arbiter_pkg;

    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } arb_state_e;

    // Index width that stays legal (>=1) even for a single requester.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gci_std_display_vram_write_arbiter_if.sv
// Requester-side and VRAM-side signals of the VRAM write arbiter.
// slave: arbiter view; master: requesters + VRAM controller view.
interface gci_std_display_vram_write_arbiter_if
    import gci_std_display_vram_write_arbiter_pkg::*;
#(
    parameter int P_N      = 2,
    parameter int P_ADDR_W = VRAM_ADDR_W,
    parameter int P_DATA_W = VRAM_DATA_W
);
    logic [P_N-1:0]          iREQ;
    logic [P_N-1:0]          iREQ_LOCK;
    logic [P_N*P_ADDR_W-1:0] iREQ_ADDR;
    logic [P_N*P_DATA_W-1:0] iREQ_DATA;
    logic [P_N-1:0]          oREQ_BUSY;
    logic [P_N-1:0]          oGRANT;
    logic                    iVRAM_WAIT;
    logic                    oVRAM_WRITE_REQ;
    logic [P_ADDR_W-1:0]     oVRAM_WRITE_ADDR;
    logic [P_DATA_W-1:0]     oVRAM_WRITE_DATA;

    modport slave (
        input  iREQ, iREQ_LOCK, iREQ_ADDR, iREQ_DATA, iVRAM_WAIT,
        output oREQ_BUSY, oGRANT,
        output oVRAM_WRITE_REQ, oVRAM_WRITE_ADDR, oVRAM_WRITE_DATA
    );

    modport master (
        output iREQ, iREQ_LOCK, iREQ_ADDR, iREQ_DATA, iVRAM_WAIT,
        input  oREQ_BUSY, oGRANT,
        input  oVRAM_WRITE_REQ, oVRAM_WRITE_ADDR, oVRAM_WRITE_DATA
    );
endinterface

// File: rtl/gci_std_display_vram_write_arbiter_rr_select.sv
// Round-robin winner select: first requesting index after ptr_i, wrapping.
// Ports: req_i requests, ptr_i last winner, grant_o one-hot winner, valid_o any winner.
module gci_std_display_rr_select
    import gci_std_display_vram_write_arbiter_pkg::*;
#(
    parameter int P_N = 2
) (
    input  logic [P_N-1:0]              req_i,
    input  logic [clog2_min1(P_N)-1:0]  ptr_i,
    output logic [P_N-1:0]              grant_o,
    output logic                        valid_o
);
    always_comb begin : sel
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        // Scan starts one past the previous winner so it gets lowest priority.
        for (int k = 1; k <= P_N; k++) begin
            idx = (int'(ptr_i) + k) % P_N;
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gci_std_display_vram_write_arbiter.sv
// Shares the VRAM write port between P_N requesters: round-robin, locked bursts, one-entry output stage.
// Ports: iCLOCK, iRESET (async, active high), bus (requester handshakes + VRAM write port).
module gci_std_display_vram_write_arbiter
    import gci_std_display_vram_write_arbiter_pkg::*;
#(
    parameter int P_N         = 2,
    parameter int P_ADDR_W    = VRAM_ADDR_W,
    parameter int P_DATA_W    = VRAM_DATA_W,
    parameter int P_MAX_BURST = 16
) (
    input  logic iCLOCK,
    input  logic iRESET,
    gci_std_display_vram_write_arbiter_if.slave bus
);
    localparam int PW = clog2_min1(P_N);
    localparam int CW = $clog2(P_MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(P_MAX_BURST);

    arb_state_e          state_q, state_d;
    logic [P_N-1:0]      grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                vreq_q, vreq_d;
    logic [P_ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [P_DATA_W-1:0] vdata_q, vdata_d;

    logic [P_N-1:0]      win;
    logic                win_valid;
    logic [PW-1:0]       win_idx;
    logic                own_req;
    logic                own_lock;
    logic [P_ADDR_W-1:0] own_addr;
    logic [P_DATA_W-1:0] own_data;
    logic                slot_free;
    logic                accept;
    logic                last_beat;

    gci_std_display_rr_select #(
        .P_N (P_N)
    ) u_rr (
        .req_i   (bus.iREQ),
        .ptr_i   (ptr_q),
        .grant_o (win),
        .valid_o (win_valid)
    );

    // Owner mux and winner index; grant_q is one-hot or zero.
    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_addr = '0;
        own_data = '0;
        win_idx  = '0;
        for (int i = 0; i < P_N; i++) begin
            if (grant_q[i]) begin
                own_req  = bus.iREQ[i];
                own_lock = bus.iREQ_LOCK[i];
                own_addr = bus.iREQ_ADDR[i*P_ADDR_W +: P_ADDR_W];
                own_data = bus.iREQ_DATA[i*P_DATA_W +: P_DATA_W];
            end
            if (win[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    // Stage can take a beat if empty or being drained this cycle.
    assign slot_free = !vreq_q || !bus.iVRAM_WAIT;
    assign accept    = (state_q == ST_OWN) && own_req && slot_free;
    assign last_beat = (cnt_q + CW'(1)) == MAX_CNT;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ARB: begin
                if (win_valid) begin
                    state_d = ST_OWN;
                    grant_d = win;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!own_lock || last_beat) begin
                        state_d = ST_ARB;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else if (!own_req && !own_lock) begin
                    state_d = ST_ARB;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Output stage: load on accept, clear valid when drained with nothing new.
    always_comb begin
        vreq_d  = vreq_q;
        vaddr_d = vaddr_q;
        vdata_d = vdata_q;
        if (accept) begin
            vreq_d  = 1'b1;
            vaddr_d = own_addr;
            vdata_d = own_data;
        end else if (vreq_q && !bus.iVRAM_WAIT) begin
            vreq_d = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= ST_ARB;
            grant_q <= '0;
            ptr_q   <= PW'(P_N - 1);
            cnt_q   <= '0;
            vreq_q  <= 1'b0;
            vaddr_q <= '0;
            vdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vreq_q  <= vreq_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
        end
    end

    assign bus.oGRANT           = grant_q;
    assign bus.oREQ_BUSY        = ~grant_q | {P_N{~slot_free}};
    assign bus.oVRAM_WRITE_REQ  = vreq_q;
    assign bus.oVRAM_WRITE_ADDR = vaddr_q;
    assign bus.oVRAM_WRITE_DATA = vdata_q;

endmodule

// File: tb/tb_gci_std_display_vram_write_arbiter.sv
// Bench for the VRAM write arbiter: bench-owned requester models feed a scoreboard of
// accepted beats, checked in order against VRAM-side consumption.
module tb_gci_std_display_vram_write_arbiter;
    localparam int N  = 2;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gci_std_display_vram_write_arbiter_if #(
        .P_N(N), .P_ADDR_W(AW), .P_DATA_W(DW)
    ) bus ();

    gci_std_display_vram_write_arbiter #(
        .P_N(N), .P_ADDR_W(AW), .P_DATA_W(DW), .P_MAX_BURST(MB)
    ) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    int    nvec = 0;
    int    nerr = 0;
    int    rem[N];
    int    seq[N];
    int    gap[N];
    bit    lmode[N];
    beat_t sb[$];
    int    acc_src[$];
    int    acc_cyc[$];
    int    cyc;
    int    consumed;

    function automatic logic [AW-1:0] mk_addr(input int i, input int s);
        return AW'(32'h10000 * i + 7 * s + 5);
    endfunction

    function automatic logic [DW-1:0] mk_data(input int i, input int s);
        return DW'((i + 1) * 4096 + s * 291 + 17);
    endfunction

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0);
        for (int i = 0; i < N; i++)
            if (rem[i] > 0 || gap[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; gap[i] = 0; lmode[i] = 1'b0;
        end
        sb.delete();
        acc_src.delete();
        acc_cyc.delete();
        cyc      = 0;
        consumed = 0;
        bus.iREQ       = '0;
        bus.iREQ_LOCK  = '0;
        bus.iREQ_ADDR  = '0;
        bus.iREQ_DATA  = '0;
        bus.iVRAM_WAIT = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0) begin
                bus.iREQ[i]      = 1'b0;
                bus.iREQ_LOCK[i] = 1'b1;
                gap[i]--;
            end else if (rem[i] > 0) begin
                bus.iREQ[i]      = 1'b1;
                bus.iREQ_LOCK[i] = lmode[i] && (rem[i] > 1);
                bus.iREQ_ADDR[i*AW +: AW] = mk_addr(i, seq[i]);
                bus.iREQ_DATA[i*DW +: DW] = mk_data(i, seq[i]);
            end else begin
                bus.iREQ[i]      = 1'b0;
                bus.iREQ_LOCK[i] = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample at negedge (consume then accept), end at posedge+1.
    task automatic cycle();
        beat_t e;
        drive();
        @(negedge clk);
        if (bus.oVRAM_WRITE_REQ && !bus.iVRAM_WAIT) begin
            nvec++;
            consumed++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL vram_beat: unexpected beat a=%h d=%h, none expected",
                         bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA);
            end else begin
                e = sb.pop_front();
                if ({bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA} !== e) begin
                    nerr++;
                    $display("FAIL vram_beat: got a=%h d=%h, want a=%h d=%h",
                             bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA, e.a, e.d);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.iREQ[i] && !bus.oREQ_BUSY[i]) begin
                sb.push_back({mk_addr(i, seq[i]), mk_data(i, seq[i])});
                acc_src.push_back(i);
                acc_cyc.push_back(cyc);
                seq[i]++;
                rem[i]--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        nvec++;
        if (pending()) begin
            nerr++;
            $display("FAIL drain: still pending after %0d cycles (sb=%0d), want empty",
                     budget, sb.size());
        end
    endtask

    task automatic wait_seq(input int i, input int target);
        int n;
        n = 0;
        while (seq[i] < target && n < 50) begin
            cycle();
            n++;
        end
        nvec++;
        if (seq[i] != target) begin
            nerr++;
            $display("FAIL wait_seq%0d: got %0d beats, want %0d", i, seq[i], target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        nvec += 5;
        if (bus.oVRAM_WRITE_REQ !== 1'b0) begin
            nerr++; $display("FAIL rst_req: got %b want 0", bus.oVRAM_WRITE_REQ);
        end
        if (bus.oGRANT !== 2'b00) begin
            nerr++; $display("FAIL rst_grant: got %b want 00", bus.oGRANT);
        end
        if (bus.oREQ_BUSY !== 2'b11) begin
            nerr++; $display("FAIL rst_busy: got %b want 11", bus.oREQ_BUSY);
        end
        if (bus.oVRAM_WRITE_ADDR !== '0) begin
            nerr++; $display("FAIL rst_addr: got %h want 0", bus.oVRAM_WRITE_ADDR);
        end
        if (bus.oVRAM_WRITE_DATA !== '0) begin
            nerr++; $display("FAIL rst_data: got %h want 0", bus.oVRAM_WRITE_DATA);
        end
        rem[0] = 1;
        cycle();
        nvec++;
        if (bus.oGRANT !== 2'b01) begin
            nerr++; $display("FAIL rst_first_grant: got %b want 01", bus.oGRANT);
        end
        drain(20);
    endtask

    task automatic test_single_beats();
        do_reset();
        rem[0] = 4;
        rem[1] = 4;
        drain(100);
        nvec++;
        if (acc_src.size() != 8) begin
            nerr++; $display("FAIL single_count: got %0d want 8", acc_src.size());
        end
        for (int k = 0; k < acc_src.size(); k++) begin
            nvec++;
            if (acc_src[k] != k % 2) begin
                nerr++; $display("FAIL single_order[%0d]: got %0d want %0d", k, acc_src[k], k % 2);
            end
            if (k > 0) begin
                nvec++;
                if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
                    nerr++;
                    $display("FAIL single_spacing[%0d]: got %0d want 2", k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_burst();
        int exp_src[$];
        do_reset();
        lmode[0] = 1'b1;
        rem[0]   = 20;
        rem[1]   = 1;
        drain(200);
        for (int k = 0; k < MB; k++) exp_src.push_back(0);
        exp_src.push_back(1);
        for (int k = 0; k < 20 - MB; k++) exp_src.push_back(0);
        nvec++;
        if (acc_src.size() != exp_src.size()) begin
            nerr++; $display("FAIL burst_count: got %0d want %0d", acc_src.size(), exp_src.size());
        end else begin
            for (int k = 0; k < exp_src.size(); k++) begin
                nvec++;
                if (acc_src[k] != exp_src[k]) begin
                    nerr++; $display("FAIL burst_order[%0d]: got %0d want %0d", k, acc_src[k], exp_src[k]);
                end
            end
            nvec += 2;
            if (acc_cyc[MB-1] - acc_cyc[0] != MB - 1) begin
                nerr++; $display("FAIL burst_b2b: got span %0d want %0d", acc_cyc[MB-1] - acc_cyc[0], MB - 1);
            end
            if (acc_cyc[MB] - acc_cyc[MB-1] != 2) begin
                nerr++; $display("FAIL burst_handover: got %0d want 2", acc_cyc[MB] - acc_cyc[MB-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        do_reset();
        lmode[0] = 1'b1;
        rem[0]   = 12;
        repeat (4) cycle();
        bus.iVRAM_WAIT = 1'b1;
        cycle();
        ca = bus.oVRAM_WRITE_ADDR;
        cd = bus.oVRAM_WRITE_DATA;
        repeat (9) begin
            cycle();
            nvec++;
            if ({bus.oVRAM_WRITE_REQ, bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA} !== {1'b1, ca, cd}) begin
                nerr++;
                $display("FAIL bp_hold: got r=%b a=%h d=%h want r=1 a=%h d=%h",
                         bus.oVRAM_WRITE_REQ, bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA, ca, cd);
            end
            nvec++;
            if ({bus.oREQ_BUSY[0], bus.oGRANT} !== 3'b1_01) begin
                nerr++;
                $display("FAIL bp_busy: got busy0=%b grant=%b want 1 01", bus.oREQ_BUSY[0], bus.oGRANT);
            end
        end
        bus.iVRAM_WAIT = 1'b0;
        drain(50);
        nvec++;
        if (consumed != 12 || seq[0] != 12) begin
            nerr++; $display("FAIL bp_total: got consumed=%0d accepted=%0d want 12", consumed, seq[0]);
        end
    endtask

    task automatic test_gap_lock();
        do_reset();
        lmode[0] = 1'b1;
        rem[0]   = 4;
        rem[1]   = 1;
        wait_seq(0, 2);
        gap[0] = 3;
        repeat (3) begin
            cycle();
            nvec++;
            if (bus.oGRANT !== 2'b01) begin
                nerr++; $display("FAIL gap_grant: got %b want 01", bus.oGRANT);
            end
        end
        drain(50);
        nvec++;
        if (acc_src.size() != 5 || acc_src[3] != 0 || acc_src[4] != 1) begin
            nerr++; $display("FAIL gap_order: got n=%0d want 0,0,0,0,1", acc_src.size());
        end
        do_reset();
        lmode[0] = 1'b1;
        rem[0]   = 3;
        wait_seq(0, 1);
        nvec++;
        if (bus.oGRANT !== 2'b01) begin
            nerr++; $display("FAIL lock_keep: got %b want 01", bus.oGRANT);
        end
        rem[0] = 0;
        cycle();
        nvec++;
        if ({bus.oGRANT, bus.oREQ_BUSY} !== 4'b00_11) begin
            nerr++; $display("FAIL drop_release: got grant=%b busy=%b want 00 11", bus.oGRANT, bus.oREQ_BUSY);
        end
        drain(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        lmode[0] = 1'b1;
        rem[0]   = 8;
        wait_seq(0, 3);
        bus.iVRAM_WAIT = 1'b1;
        cycle();
        cycle();
        nvec++;
        if (bus.oVRAM_WRITE_REQ !== 1'b1) begin
            nerr++; $display("FAIL mid_pending: got %b want 1", bus.oVRAM_WRITE_REQ);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({bus.oVRAM_WRITE_REQ, bus.oGRANT, bus.oREQ_BUSY, bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA}
            !== {1'b0, 2'b00, 2'b11, {AW{1'b0}}, {DW{1'b0}}}) begin
            nerr++;
            $display("FAIL mid_reset: got r=%b g=%b b=%b a=%h d=%h want 0 00 11 0 0",
                     bus.oVRAM_WRITE_REQ, bus.oGRANT, bus.oREQ_BUSY,
                     bus.oVRAM_WRITE_ADDR, bus.oVRAM_WRITE_DATA);
        end
        clear_bench();
        @(posedge clk);
        #1 rst = 1'b0;
        rem[0] = 1;
        rem[1] = 1;
        cycle();
        nvec++;
        if (bus.oGRANT !== 2'b01) begin
            nerr++; $display("FAIL mid_first_grant: got %b want 01", bus.oGRANT);
        end
        drain(30);
    endtask

    initial begin
        test_reset();
        test_single_beats();
        test_burst();
        test_backpressure();
        test_gap_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
